// File: rtl/steer_pkg.sv
// Shared types and default thresholds for the rider-presence / steering-enable controller.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } state_t;

  localparam logic [11:0] DEF_MIN_RIDER_WEIGHT = 12'h200;
  localparam logic [11:0] DEF_HYSTERESIS       = 12'h040;

endpackage

// File: rtl/steer_en_hyst_if.sv
// Load-cell inputs and steering/status outputs of the steering-enable controller.
interface steer_en_hyst_if #(
  parameter int LD_W = 12
);

  logic [LD_W-1:0] ld_cell_sum;
  logic [LD_W-1:0] ld_cell_diff;
  logic            en_steer;
  logic            rider_off;
  logic            tmr_full;
  logic [1:0]      state_o;

  modport master (
    output ld_cell_sum, ld_cell_diff,
    input  en_steer, rider_off, tmr_full, state_o
  );

  modport slave (
    input  ld_cell_sum, ld_cell_diff,
    output en_steer, rider_off, tmr_full, state_o
  );

endinterface

// File: rtl/steer_settle_tmr.sv
// Saturating settle timer: counts while run is high, clears on clr or when not running.
module steer_settle_tmr #(
  parameter int SETTLE_BITS = 26,
  parameter int FAST_SIM    = 0,
  parameter int FAST_BITS   = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic full
);

  // Terminal count is all-ones of the selected width, so full is a simple AND-reduce.
  localparam int CNT_W = (FAST_SIM != 0) ? FAST_BITS : SETTLE_BITS;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign full = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (!full) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/steer_en_hyst.sv
// Rider-presence and steering-enable controller: registered load-cell compares
// feeding an IDLE/WAIT/STEER_EN FSM with a settle timer.
module steer_en_hyst
  import steer_pkg::*;
#(
  parameter int              LD_W             = 12,
  parameter logic [LD_W-1:0] MIN_RIDER_WEIGHT = LD_W'(DEF_MIN_RIDER_WEIGHT),
  parameter logic [LD_W-1:0] HYSTERESIS       = LD_W'(DEF_HYSTERESIS),
  parameter int              ENTER_SHIFT      = 3,
  parameter int              EXIT_NUM         = 15,
  parameter int              EXIT_SHIFT       = 4,
  parameter int              SETTLE_BITS      = 26,
  parameter int              FAST_SIM         = 0,
  parameter int              FAST_BITS        = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  steer_en_hyst_if.slave  bus
);

  if (HYSTERESIS >= MIN_RIDER_WEIGHT) begin : g_bad_hyst
    $error("steer_en_hyst: HYSTERESIS must be smaller than MIN_RIDER_WEIGHT");
  end

  // Band edges carry one extra bit so MIN+HYST cannot overflow.
  localparam logic [LD_W:0] SUM_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [LD_W:0] SUM_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};
  localparam int            PROD_W = LD_W + $clog2(EXIT_NUM + 1);

  logic [LD_W:0]     sum_ext;
  logic [LD_W-1:0]   enter_thr;
  logic [PROD_W-1:0] exit_prod;
  logic [PROD_W-1:0] exit_thr;
  logic [PROD_W-1:0] diff_ext;

  logic sum_gt_q, sum_lt_q, diff_gt_enter_q, diff_gt_exit_q;

  state_t state_q, state_d;
  logic   clr_tmr;
  logic   rider_off_d, rider_off_q;
  logic   en_steer_q;
  logic   tmr_full;

  assign sum_ext   = {1'b0, bus.ld_cell_sum};
  assign enter_thr = bus.ld_cell_sum >> ENTER_SHIFT;
  assign exit_prod = PROD_W'(bus.ld_cell_sum) * PROD_W'(EXIT_NUM);
  assign exit_thr  = exit_prod >> EXIT_SHIFT;
  assign diff_ext  = PROD_W'(bus.ld_cell_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_gt_q        <= 1'b0;
      sum_lt_q        <= 1'b0;
      diff_gt_enter_q <= 1'b0;
      diff_gt_exit_q  <= 1'b0;
    end else begin
      sum_gt_q        <= (sum_ext > SUM_HI);
      sum_lt_q        <= (sum_ext < SUM_LO);
      diff_gt_enter_q <= (bus.ld_cell_diff > enter_thr);
      diff_gt_exit_q  <= (diff_ext > exit_thr);
    end
  end

  // Inside the hysteresis band both sum flags are low, so every state holds.
  always_comb begin
    state_d     = state_q;
    clr_tmr     = 1'b0;
    rider_off_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sum_gt_q) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_q) begin
          state_d     = IDLE;
          rider_off_d = 1'b1;
        end else if (diff_gt_enter_q) begin
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          state_d = STEER_EN;
        end
      end
      STEER_EN: begin
        if (sum_lt_q) begin
          state_d     = IDLE;
          rider_off_d = 1'b1;
        end else if (diff_gt_exit_q) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rider_off_q <= 1'b0;
      en_steer_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rider_off_q <= rider_off_d;
      en_steer_q  <= (state_q == STEER_EN);
    end
  end

  steer_settle_tmr #(
    .SETTLE_BITS (SETTLE_BITS),
    .FAST_SIM    (FAST_SIM),
    .FAST_BITS   (FAST_BITS)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == WAIT),
    .clr   (clr_tmr),
    .full  (tmr_full)
  );

  assign bus.en_steer  = en_steer_q;
  assign bus.rider_off = rider_off_q;
  assign bus.tmr_full  = tmr_full;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_steer_en_hyst.sv
// Directed-vector bench for steer_en_hyst with the fast settle timer (terminal count 32767).
module tb_steer_en_hyst;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec   = 0;
  int n_err   = 0;
  int ro_cnt  = 0;
  int ro_long = 0;
  int tf_rise = 0;
  logic ro_prev = 1'b0;
  logic tf_prev = 1'b0;

  steer_en_hyst_if #(.LD_W(12)) bus ();

  steer_en_hyst #(
    .LD_W      (12),
    .FAST_SIM  (1),
    .FAST_BITS (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count rider_off pulses, over-long pulses and tmr_full rising edges.
  always @(negedge clk) begin
    if (bus.rider_off === 1'b1) ro_cnt <= ro_cnt + 1;
    if (bus.rider_off === 1'b1 && ro_prev === 1'b1) ro_long <= ro_long + 1;
    if (bus.tmr_full === 1'b1 && tf_prev !== 1'b1) tf_rise <= tf_rise + 1;
    ro_prev <= bus.rider_off;
    tf_prev <= bus.tmr_full;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input int lim, output int n);
    n = 0;
    while (bus.en_steer !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [11:0] sweep [4];
    int n;
    int tf0;
    int ro0;

    sweep[0] = 12'h1D0;
    sweep[1] = 12'h230;
    sweep[2] = 12'h1C8;
    sweep[3] = 12'h300;

    bus.ld_cell_sum  = 12'h100;
    bus.ld_cell_diff = 12'h000;
    rst_n = 1'b0;
    tick(3);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_en", 32'(bus.en_steer), 32'd0);
    chk("rst_rider_off", 32'(bus.rider_off), 32'd0);
    chk("rst_tmr_full", 32'(bus.tmr_full), 32'd0);

    rst_n = 1'b1;
    tick(100);
    chk("idle_state", 32'(bus.state_o), 32'd0);
    chk("idle_en", 32'(bus.en_steer), 32'd0);
    chk("idle_ro_count", 32'(ro_cnt), 32'd0);

    // Mount: flag after 1 edge, WAIT after 2, en_steer 32769 edges later.
    bus.ld_cell_sum  = 12'h300;
    bus.ld_cell_diff = 12'h010;
    tick(1);
    chk("mount_e1_state", 32'(bus.state_o), 32'd0);
    tick(1);
    chk("mount_e2_state", 32'(bus.state_o), 32'd1);
    tf0 = tf_rise;
    wait_en(40000, n);
    chk("mount_settle_cycles", 32'(n), 32'd32769);
    chk("mount_state", 32'(bus.state_o), 32'd2);
    chk("mount_tmr_full_once", 32'(tf_rise - tf0), 32'd1);

    // Step-off boundary: 0x2D0 equals (0x300*15)>>4, not above it.
    bus.ld_cell_diff = 12'h2D0;
    tick(8);
    chk("stepoff_eq_state", 32'(bus.state_o), 32'd2);
    chk("stepoff_eq_en", 32'(bus.en_steer), 32'd1);
    bus.ld_cell_diff = 12'h2E0;
    tick(2);
    chk("stepoff_state", 32'(bus.state_o), 32'd1);
    chk("stepoff_en_lag", 32'(bus.en_steer), 32'd1);
    tick(1);
    chk("stepoff_en_drop", 32'(bus.en_steer), 32'd0);
    chk("stepoff_tmr_clr", 32'(bus.tmr_full), 32'd0);

    // Imbalance holds the timer at zero; settling restarts from the diff drop.
    bus.ld_cell_diff = 12'h070;
    tick(1000);
    chk("imb_state", 32'(bus.state_o), 32'd1);
    chk("imb_en", 32'(bus.en_steer), 32'd0);
    chk("imb_tmr_full", 32'(bus.tmr_full), 32'd0);
    bus.ld_cell_diff = 12'h010;
    tf0 = tf_rise;
    wait_en(40000, n);
    chk("imb_settle_cycles", 32'(n), 32'd32770);
    chk("imb_tmr_full_once", 32'(tf_rise - tf0), 32'd1);
    chk("imb_state_steer", 32'(bus.state_o), 32'd2);

    // Hysteresis sweep stays in STEER_EN; 0x1B0 drops below 0x1C0.
    for (int i = 0; i < 4; i++) begin
      bus.ld_cell_sum = sweep[i];
      tick(8);
      chk($sformatf("hyst_%0h_state", sweep[i]), 32'(bus.state_o), 32'd2);
      chk($sformatf("hyst_%0h_en", sweep[i]), 32'(bus.en_steer), 32'd1);
    end
    ro0 = ro_cnt;
    bus.ld_cell_sum = 12'h1B0;
    tick(2);
    chk("off_state", 32'(bus.state_o), 32'd0);
    chk("off_rider_off", 32'(bus.rider_off), 32'd1);
    tick(1);
    chk("off_rider_off_end", 32'(bus.rider_off), 32'd0);
    chk("off_en", 32'(bus.en_steer), 32'd0);
    tick(5);
    chk("off_ro_pulses", 32'(ro_cnt - ro0), 32'd1);
    chk("ro_long_pulses", 32'(ro_long), 32'd0);

    // Async reset in the middle of WAIT at counter 20000.
    bus.ld_cell_sum  = 12'h300;
    bus.ld_cell_diff = 12'h010;
    tick(2);
    chk("ar_wait_state", 32'(bus.state_o), 32'd1);
    tick(20000);
    chk("ar_cnt_before", 32'(dut.u_tmr.cnt_q), 32'd20000);
    chk("ar_state_before", 32'(bus.state_o), 32'd1);
    ro0 = ro_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state_now", 32'(bus.state_o), 32'd0);
    chk("ar_cnt_now", 32'(dut.u_tmr.cnt_q), 32'd0);
    chk("ar_rider_off_now", 32'(bus.rider_off), 32'd0);
    tick(3);
    rst_n = 1'b1;
    chk("ar_no_ro_pulse", 32'(ro_cnt - ro0), 32'd0);
    tick(2);
    chk("ar_remount_state", 32'(bus.state_o), 32'd1);
    chk("ar_remount_cnt", 32'(dut.u_tmr.cnt_q), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
